// File: rtl/stack_ctrl_if.sv
// Bundle between the stack controller, its requester and the register file.
// The slave modport is the controller's view; master is the requester/register-file side.
interface stack_ctrl_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 2
);
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] push_data;
  logic [DATA_WIDTH-1:0] mem_r_data;
  logic                  mem_wr_en;
  logic [ADDR_WIDTH-1:0] mem_w_addr;
  logic [DATA_WIDTH-1:0] mem_w_data;
  logic [ADDR_WIDTH-1:0] mem_r_addr;
  logic [DATA_WIDTH-1:0] pop_data;
  logic                  pop_valid;
  logic [DATA_WIDTH-1:0] top_data;
  logic [ADDR_WIDTH:0]   count;
  logic                  full;
  logic                  empty;
  logic                  overflow;
  logic                  underflow;

  modport slave (
    input  push, pop, push_data, mem_r_data,
    output mem_wr_en, mem_w_addr, mem_w_data, mem_r_addr,
           pop_data, pop_valid, top_data, count, full, empty, overflow, underflow
  );

  modport master (
    output push, pop, push_data, mem_r_data,
    input  mem_wr_en, mem_w_addr, mem_w_data, mem_r_addr,
           pop_data, pop_valid, top_data, count, full, empty, overflow, underflow
  );
endinterface

// File: rtl/stack_ctrl.sv
// LIFO policy and pointer logic in front of a single-port-write, async-read register file.
// Popped words come back registered; simultaneous push+pop replaces the top in place.
module stack_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 2
) (
  input logic         clk,
  input logic         reset,
  stack_ctrl_if.slave bus
);

  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_popData;
  logic                  r_popValid;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_full;
  logic                  w_empty;
  logic [ADDR_WIDTH:0]   w_countMinus1;
  logic [ADDR_WIDTH-1:0] w_topAddr;
  logic                  w_doPush;
  logic                  w_doPop;

  assign w_full        = (r_count == DEPTH);
  assign w_empty       = (r_count == '0);
  assign w_countMinus1 = r_count - 1'b1;
  assign w_topAddr     = w_empty ? '0 : w_countMinus1[ADDR_WIDTH-1:0];

  // A push while full is only legal when paired with a pop (replace of the top).
  assign w_doPush = bus.push && !reset && (!w_full || bus.pop);
  assign w_doPop  = bus.pop  && !reset && !w_empty;

  assign bus.mem_wr_en  = w_doPush;
  assign bus.mem_w_addr = w_doPop ? w_topAddr : r_count[ADDR_WIDTH-1:0];
  assign bus.mem_w_data = bus.push_data;
  assign bus.mem_r_addr = w_topAddr;
  assign bus.top_data   = w_empty ? '0 : bus.mem_r_data;
  assign bus.count      = r_count;
  assign bus.full       = w_full;
  assign bus.empty      = w_empty;
  assign bus.pop_data   = r_popData;
  assign bus.pop_valid  = r_popValid;
  assign bus.overflow   = r_overflow;
  assign bus.underflow  = r_underflow;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count     <= '0;
      r_popData   <= '0;
      r_popValid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_doPush && !w_doPop) begin
        r_count <= r_count + 1'b1;
      end else if (w_doPop && !w_doPush) begin
        r_count <= r_count - 1'b1;
      end
      // On replace, mem_r_data still shows the old top because the write lands on this same edge.
      r_popValid <= w_doPop;
      if (w_doPop) begin
        r_popData <= bus.mem_r_data;
      end
      if (bus.push && !bus.pop && w_full) begin
        r_overflow <= 1'b1;
      end
      if (bus.pop && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl with a small register file and a queue-based LIFO reference model.
// Directed scenarios first, then randomized push/pop/reset traffic.
module tb_stack_ctrl;

  localparam int AW    = 2;
  localparam int DW    = 2;
  localparam int DEPTH = 1 << AW;

  logic clk;
  logic reset;

  stack_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  stack_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [DW-1:0] regFile [DEPTH];

  assign bus.mem_r_data = regFile[bus.mem_r_addr];

  always @(posedge clk) begin
    if (bus.mem_wr_en) begin
      regFile[bus.mem_w_addr] <= bus.mem_w_data;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [DW-1:0] stk [$];
  logic [DW-1:0] mPopData;
  logic          mPopValid;
  logic          mOverflow;
  logic          mUnderflow;

  int assertCount = 0;
  int failCount   = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic modelStep(input logic r, input logic p, input logic q, input logic [DW-1:0] d);
    int sz;
    sz = stk.size();
    if (r) begin
      stk.delete();
      mPopData   = '0;
      mPopValid  = 1'b0;
      mOverflow  = 1'b0;
      mUnderflow = 1'b0;
    end else if (p && q && sz > 0) begin
      mPopData     = stk[sz-1];
      mPopValid    = 1'b1;
      stk[sz-1]    = d;
    end else begin
      mPopValid = 1'b0;
      if (q) begin
        if (sz > 0) begin
          mPopData  = stk.pop_back();
          mPopValid = 1'b1;
        end else begin
          mUnderflow = 1'b1;
        end
      end
      if (p) begin
        if (stk.size() < DEPTH) stk.push_back(d);
        else mOverflow = 1'b1;
      end
    end
  endtask

  // One cycle: drive at the falling edge, check combinational outputs, clock, check registered state.
  task automatic applyStimulus(input logic r, input logic p, input logic q, input logic [DW-1:0] d);
    int  sz;
    logic expWrEn;
    int  expWAddr;
    reset         = r;
    bus.push      = p;
    bus.pop       = q;
    bus.push_data = d;
    #1;
    sz       = stk.size();
    expWrEn  = !r && p && (sz < DEPTH || q);
    expWAddr = (q && sz > 0) ? sz - 1 : sz;
    checkOutput("mem_wr_en", 32'(bus.mem_wr_en), 32'(expWrEn));
    if (expWrEn) begin
      checkOutput("mem_w_addr", 32'(bus.mem_w_addr), 32'(expWAddr));
      checkOutput("mem_w_data", 32'(bus.mem_w_data), 32'(d));
    end
    checkOutput("mem_r_addr", 32'(bus.mem_r_addr), 32'(sz == 0 ? 0 : sz - 1));
    checkOutput("top_data", 32'(bus.top_data), sz == 0 ? 32'd0 : 32'(stk[sz-1]));
    @(posedge clk);
    modelStep(r, p, q, d);
    @(negedge clk);
    checkOutput("count", 32'(bus.count), 32'(stk.size()));
    checkOutput("full", 32'(bus.full), 32'(stk.size() == DEPTH));
    checkOutput("empty", 32'(bus.empty), 32'(stk.size() == 0));
    checkOutput("pop_valid", 32'(bus.pop_valid), 32'(mPopValid));
    checkOutput("pop_data", 32'(bus.pop_data), 32'(mPopData));
    checkOutput("overflow", 32'(bus.overflow), 32'(mOverflow));
    checkOutput("underflow", 32'(bus.underflow), 32'(mUnderflow));
  endtask

  initial begin
    mPopData   = '0;
    mPopValid  = 1'b0;
    mOverflow  = 1'b0;
    mUnderflow = 1'b0;
    reset         = 1'b1;
    bus.push      = 1'b1;
    bus.pop       = 1'b0;
    bus.push_data = 2'd1;
    @(negedge clk);

    // Reset held with push requested
    applyStimulus(1, 1, 0, 2'd1);
    applyStimulus(1, 1, 0, 2'd2);

    // LIFO order
    applyStimulus(0, 1, 0, 2'd1);
    applyStimulus(0, 1, 0, 2'd2);
    applyStimulus(0, 1, 0, 2'd3);
    applyStimulus(0, 0, 1, 2'd0);
    checkOutput("lifo_first", 32'(bus.pop_data), 32'd3);
    applyStimulus(0, 0, 1, 2'd0);
    applyStimulus(0, 0, 1, 2'd0);
    checkOutput("lifo_last", 32'(bus.pop_data), 32'd1);

    // Pop when empty
    applyStimulus(0, 0, 1, 2'd0);

    // Fill, overflow, pop
    applyStimulus(1, 0, 0, 2'd0);
    applyStimulus(0, 1, 0, 2'd2);
    applyStimulus(0, 1, 0, 2'd1);
    applyStimulus(0, 1, 0, 2'd3);
    applyStimulus(0, 1, 0, 2'd2);
    applyStimulus(0, 1, 0, 2'd1);
    applyStimulus(0, 0, 1, 2'd0);
    applyStimulus(0, 1, 0, 2'd3);

    // Replace on a full stack, then observe the new top
    applyStimulus(0, 1, 1, 2'd0);
    applyStimulus(0, 0, 0, 2'd0);

    // Push and pop on an empty stack
    applyStimulus(1, 0, 0, 2'd0);
    applyStimulus(0, 1, 1, 2'd2);
    applyStimulus(0, 0, 0, 2'd0);

    // Reset mid-sequence at count 3
    applyStimulus(0, 1, 0, 2'd1);
    applyStimulus(0, 1, 0, 2'd3);
    applyStimulus(1, 1, 0, 2'd2);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 59) == 0), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 2) == 0, DW'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
